// File: rtl/alu_ctrl_pkg.sv
// Shared encodings, FSM states and the decoded-instruction record for the
// execute-stage ALU sequencer.
package alu_ctrl_pkg;

    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_SUB = 3'd1;
    localparam logic [2:0] SEL_AND = 3'd2;
    localparam logic [2:0] SEL_OR  = 3'd3;
    localparam logic [2:0] SEL_SLT = 3'd4;
    localparam logic [2:0] SEL_MUL = 3'd5;
    localparam logic [2:0] SEL_DIV = 3'd6;
    localparam logic [2:0] SEL_NOP = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        IMM_REG = 2'd0,
        IMM_SE  = 2'd1,
        IMM_ZE  = 2'd2
    } imm_mode_e;

    typedef enum logic {
        DEST_RT = 1'b0,
        DEST_RD = 1'b1
    } dest_sel_e;

    typedef struct packed {
        logic [2:0] sel;
        imm_mode_e  imm_mode;
        dest_sel_e  dest_sel;
        logic       wb;
        logic       mem_rd;
        logic       mem_wr;
        logic       is_beq;
        logic       is_div;
        logic       illegal;
    } dec_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decoder producing the control record consumed
// by the sequencer at accept time.
module alu_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    // Start from the illegal-instruction record and fill in recognised encodings.
    always_comb begin
        o_dec.sel      = SEL_NOP;
        o_dec.imm_mode = IMM_REG;
        o_dec.dest_sel = DEST_RT;
        o_dec.wb       = 1'b0;
        o_dec.mem_rd   = 1'b0;
        o_dec.mem_wr   = 1'b0;
        o_dec.is_beq   = 1'b0;
        o_dec.is_div   = 1'b0;
        o_dec.illegal  = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.dest_sel = DEST_RD;
                o_dec.wb       = 1'b1;
                o_dec.illegal  = 1'b0;
                case (i_funct)
                    FN_ADD: o_dec.sel = SEL_ADD;
                    FN_AND: o_dec.sel = SEL_AND;
                    FN_OR:  o_dec.sel = SEL_OR;
                    FN_SLT: o_dec.sel = SEL_SLT;
                    FN_MUL: o_dec.sel = SEL_MUL;
                    FN_DIV: begin
                        o_dec.sel    = SEL_DIV;
                        o_dec.is_div = 1'b1;
                    end
                    default: begin
                        o_dec.dest_sel = DEST_RT;
                        o_dec.wb       = 1'b0;
                        o_dec.illegal  = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                o_dec.sel      = (i_opcode == OP_ADDI) ? SEL_ADD : SEL_SLT;
                o_dec.imm_mode = IMM_SE;
                o_dec.wb       = 1'b1;
                o_dec.illegal  = 1'b0;
            end
            OP_ANDI, OP_ORI: begin
                o_dec.sel      = (i_opcode == OP_ANDI) ? SEL_AND : SEL_OR;
                o_dec.imm_mode = IMM_ZE;
                o_dec.wb       = 1'b1;
                o_dec.illegal  = 1'b0;
            end
            OP_LW: begin
                o_dec.sel      = SEL_ADD;
                o_dec.imm_mode = IMM_SE;
                o_dec.wb       = 1'b1;
                o_dec.mem_rd   = 1'b1;
                o_dec.illegal  = 1'b0;
            end
            OP_SW: begin
                o_dec.sel      = SEL_ADD;
                o_dec.imm_mode = IMM_SE;
                o_dec.mem_wr   = 1'b1;
                o_dec.illegal  = 1'b0;
            end
            OP_BEQ: begin
                o_dec.sel     = SEL_SUB;
                o_dec.is_beq  = 1'b1;
                o_dec.illegal = 1'b0;
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state execute-stage controller: registers ALU operands on accept,
// captures the external ALU result one cycle later, and holds it under valid/ready.
module alu_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic [4:0]  rt_idx,
    input  logic [4:0]  rd_idx,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_r,
    input  logic        alu_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_dest,
    output logic        res_wb,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        br_taken,
    output logic        err
);

    state_e      r_state;
    state_e      w_next_state;
    dec_t        w_dec;
    logic        w_accept;
    logic        w_div_zero;
    logic [31:0] w_y;

    logic [31:0] r_alu_x, r_alu_y;
    logic [2:0]  r_alu_sel;
    logic [4:0]  r_p_dest;
    logic        r_p_wb, r_p_mrd, r_p_mwr, r_p_beq, r_p_err;
    logic [31:0] r_res_data;
    logic [4:0]  r_res_dest;
    logic        r_res_wb, r_mem_rd, r_mem_wr, r_br_taken, r_err;

    alu_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_dec    (w_dec)
    );

    assign w_accept   = in_valid & (r_state == ST_IDLE);
    assign w_div_zero = w_dec.is_div & (rt_val == 32'd0);

    // Operand Y source selected by the decoded immediate mode.
    always_comb begin
        w_y = rt_val;
        case (w_dec.imm_mode)
            IMM_SE:  w_y = sign_ext16(imm);
            IMM_ZE:  w_y = zero_ext16(imm);
            default: w_y = rt_val;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = in_valid ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next_state = ST_DONE;
            ST_DONE: w_next_state = out_ready ? ST_IDLE : ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_EXEC: in_ready  = 1'b0;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operands and decoded flags load on accept; results load only when leaving EXEC,
    // so every output is stable for as long as DONE is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_x    <= 32'd0;
            r_alu_y    <= 32'd0;
            r_alu_sel  <= SEL_NOP;
            r_p_dest   <= 5'd0;
            r_p_wb     <= 1'b0;
            r_p_mrd    <= 1'b0;
            r_p_mwr    <= 1'b0;
            r_p_beq    <= 1'b0;
            r_p_err    <= 1'b0;
            r_res_data <= 32'd0;
            r_res_dest <= 5'd0;
            r_res_wb   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_br_taken <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_alu_x   <= rs_val;
            r_alu_y   <= w_y;
            r_alu_sel <= w_dec.sel;
            r_p_dest  <= w_dec.illegal ? 5'd0 :
                         ((w_dec.dest_sel == DEST_RD) ? rd_idx : rt_idx);
            r_p_wb    <= w_dec.wb & ~w_div_zero;
            r_p_mrd   <= w_dec.mem_rd;
            r_p_mwr   <= w_dec.mem_wr;
            r_p_beq   <= w_dec.is_beq;
            r_p_err   <= w_dec.illegal | w_div_zero;
        end else if (r_state == ST_EXEC) begin
            r_res_data <= r_p_err ? 32'd0 : alu_r;
            r_res_dest <= r_p_dest;
            r_res_wb   <= r_p_wb;
            r_mem_rd   <= r_p_mrd;
            r_mem_wr   <= r_p_mwr;
            r_br_taken <= r_p_beq & alu_z;
            r_err      <= r_p_err;
        end else begin
            r_res_data <= r_res_data;
        end
    end

    assign alu_x    = r_alu_x;
    assign alu_y    = r_alu_y;
    assign alu_sel  = r_alu_sel;
    assign res_data = r_res_data;
    assign res_dest = r_res_dest;
    assign res_wb   = r_res_wb;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign br_taken = r_br_taken;
    assign err      = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: directed vector table, randomized instructions against a
// behavioural model, plus backpressure and mid-operation reset sequences.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_val, rt_val, alu_x, alu_y, alu_r, res_data;
    logic [15:0] imm;
    logic [4:0]  rt_idx, rd_idx, res_dest;
    logic [2:0]  alu_sel;
    logic        alu_z, res_wb, mem_rd, mem_wr, br_taken, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        wb, mrd, mwr, br, err;
    } exp_t;

    typedef struct {
        logic [5:0]  op, fn;
        logic [31:0] rs, rt;
        logic [15:0] imm;
        logic [4:0]  rti, rdi;
        exp_t        exp;
    } vec_t;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_r(alu_r), .alu_z(alu_z),
        .out_valid(out_valid), .out_ready(out_ready), .res_data(res_data),
        .res_dest(res_dest), .res_wb(res_wb), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .br_taken(br_taken), .err(err)
    );

    // The execute-stage ALU that sits beside the sequencer.
    always_comb begin
        case (alu_sel)
            3'd0: alu_r = alu_x + alu_y;
            3'd1: alu_r = alu_x - alu_y;
            3'd2: alu_r = alu_x & alu_y;
            3'd3: alu_r = alu_x | alu_y;
            3'd4: alu_r = (alu_x < alu_y) ? 32'd1 : 32'd0;
            3'd5: alu_r = alu_x * alu_y;
            3'd6: alu_r = (alu_y == 32'd0) ? 32'hFFFF_FFFF : alu_x / alu_y;
            default: alu_r = alu_x;
        endcase
    end
    assign alu_z = (alu_r == 32'd0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] im, input logic [4:0] rti,
                                   input logic [4:0] rdi);
        exp_t e;
        logic [31:0] se, ze;
        se = {{16{im[15]}}, im};
        ze = {16'h0000, im};
        e = '0;
        if (op == 6'h00) begin
            e.dest = rdi;
            e.wb   = 1'b1;
            case (fn)
                6'h20: e.data = rs + rt;
                6'h24: e.data = rs & rt;
                6'h25: e.data = rs | rt;
                6'h2A: e.data = (rs < rt) ? 32'd1 : 32'd0;
                6'h18: e.data = rs * rt;
                6'h1A: if (rt == 32'd0) begin e.err = 1'b1; e.wb = 1'b0; end
                       else e.data = rs / rt;
                default: begin e.err = 1'b1; e.wb = 1'b0; e.dest = 5'd0; end
            endcase
        end else begin
            e.dest = rti;
            case (op)
                6'h08: begin e.data = rs + se; e.wb = 1'b1; end
                6'h0A: begin e.data = (rs < se) ? 32'd1 : 32'd0; e.wb = 1'b1; end
                6'h0C: begin e.data = rs & ze; e.wb = 1'b1; end
                6'h0D: begin e.data = rs | ze; e.wb = 1'b1; end
                6'h23: begin e.data = rs + se; e.wb = 1'b1; e.mrd = 1'b1; end
                6'h2B: begin e.data = rs + se; e.mwr = 1'b1; end
                6'h04: begin e.data = rs - rt; e.br = (rs == rt); end
                default: begin e.err = 1'b1; e.dest = 5'd0; end
            endcase
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] im, input logic [4:0] rti,
                                input logic [4:0] rdi, input logic [31:0] d,
                                input logic [4:0] dst, input logic wb, input logic mrd,
                                input logic mwr, input logic br, input logic er);
        vec_t v;
        v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = im; v.rti = rti; v.rdi = rdi;
        v.exp.data = d; v.exp.dest = dst; v.exp.wb = wb; v.exp.mrd = mrd;
        v.exp.mwr = mwr; v.exp.br = br; v.exp.err = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        opcode = v.op; funct = v.fn; rs_val = v.rs; rt_val = v.rt;
        imm = v.imm; rt_idx = v.rti; rd_idx = v.rdi;
    endtask

    // One full transaction: accept, EXEC, first DONE cycle checks, release.
    task automatic run(input vec_t v, input string tag);
        logic ill;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " exec_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " exec_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, res_data, v.exp.data);
        chk({tag, " dest"}, 32'(res_dest), 32'(v.exp.dest));
        chk({tag, " wb"}, 32'(res_wb), 32'(v.exp.wb));
        chk({tag, " mem_rd"}, 32'(mem_rd), 32'(v.exp.mrd));
        chk({tag, " mem_wr"}, 32'(mem_wr), 32'(v.exp.mwr));
        chk({tag, " br"}, 32'(br_taken), 32'(v.exp.br));
        chk({tag, " err"}, 32'(err), 32'(v.exp.err));
        chk({tag, " alu_x"}, alu_x, v.rs);
        ill = v.exp.err & ~((v.op == 6'h00) && (v.fn == 6'h1A));
        if (ill) chk({tag, " nop_sel"}, 32'(alu_sel), 32'd7);
        else     chk({tag, " legal_sel"}, 32'(alu_sel != 3'd7), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " release_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " alu_x"}, alu_x, 32'd0);
        chk({tag, " alu_y"}, alu_y, 32'd0);
        chk({tag, " alu_sel"}, 32'(alu_sel), 32'd7);
        chk({tag, " res_data"}, res_data, 32'd0);
        chk({tag, " flags"}, {20'd0, 7'(res_dest), res_wb, mem_rd, mem_wr, br_taken, err}, 32'd0);
    endtask

    vec_t vq[$];
    logic [5:0] ops[9] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};
    logic [5:0] fns[7] = '{6'h20, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h00};

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 6'd0; funct = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
        imm = 16'd0; rt_idx = 5'd0; rd_idx = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        vq.push_back(mk(6'h00, 6'h20, 32'd7, 32'd5, 16'h0000, 5'd2, 5'd3, 32'd12, 5'd3, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h08, 6'h00, 32'h10, 32'd0, 16'hFFFF, 5'd4, 5'd1, 32'h0000000F, 5'd4, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h0C, 6'h00, 32'hFFFF00FF, 32'd0, 16'hFFFF, 5'd6, 5'd1, 32'h000000FF, 5'd6, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h04, 6'h00, 32'd9, 32'd9, 16'h0000, 5'd7, 5'd1, 32'd0, 5'd7, 0, 0, 0, 1, 0));
        vq.push_back(mk(6'h04, 6'h00, 32'd9, 32'd4, 16'h0000, 5'd7, 5'd1, 32'd5, 5'd7, 0, 0, 0, 0, 0));
        vq.push_back(mk(6'h23, 6'h00, 32'h1000, 32'd0, 16'hFFFC, 5'd8, 5'd2, 32'h00000FFC, 5'd8, 1, 1, 0, 0, 0));
        vq.push_back(mk(6'h2B, 6'h00, 32'h1000, 32'd0, 16'hFFFC, 5'd8, 5'd2, 32'h00000FFC, 5'd8, 0, 0, 1, 0, 0));
        vq.push_back(mk(6'h00, 6'h1A, 32'd50, 32'd0, 16'h0000, 5'd1, 5'd10, 32'd0, 5'd10, 0, 0, 0, 0, 1));
        vq.push_back(mk(6'h3F, 6'h00, 32'd50, 32'd3, 16'h1234, 5'd1, 5'd10, 32'd0, 5'd0, 0, 0, 0, 0, 1));
        vq.push_back(mk(6'h0D, 6'h00, 32'hF0000000, 32'd0, 16'h8001, 5'd11, 5'd1, 32'hF0008001, 5'd11, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h00, 6'h2A, 32'd5, 32'hFFFFFFFF, 16'h0000, 5'd1, 5'd12, 32'd1, 5'd12, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h00, 6'h18, 32'h00010000, 32'h00010001, 16'h0000, 5'd1, 5'd13, 32'h00010000, 5'd13, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h00, 6'h00, 32'd1, 32'd2, 16'h0000, 5'd1, 5'd14, 32'd0, 5'd0, 0, 0, 0, 0, 1));
        vq.push_back(mk(6'h0A, 6'h00, 32'd3, 32'd0, 16'hFFFF, 5'd15, 5'd1, 32'd1, 5'd15, 1, 0, 0, 0, 0));
        vq.push_back(mk(6'h00, 6'h1A, 32'd100, 32'd7, 16'h0000, 5'd1, 5'd16, 32'd14, 5'd16, 1, 0, 0, 0, 0));
        foreach (vq[i]) run(vq[i], $sformatf("vec%0d", i));

        // Randomized instructions against the behavioural model.
        for (int n = 0; n < 60; n++) begin
            v.op  = ops[$urandom_range(0, 8)];
            v.fn  = fns[$urandom_range(0, 6)];
            if (v.op == 6'h3F) v.op = 6'($urandom_range(0, 63));
            v.rs  = $urandom;
            v.rt  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) v.rt = v.rs;
            v.imm = 16'($urandom);
            v.rti = 5'($urandom);
            v.rdi = 5'($urandom);
            v.exp = model(v.op, v.fn, v.rs, v.rt, v.imm, v.rti, v.rdi);
            run(v, $sformatf("rnd%0d", n));
        end

        // Backpressure: DONE held for 5 cycles while a new instruction is offered.
        @(negedge clk);
        drive(mk(6'h00, 6'h20, 32'd100, 32'd23, 16'h0, 5'd1, 5'd9, 32'd0, 5'd0, 0, 0, 0, 0, 0));
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(mk(6'h2B, 6'h00, 32'd1, 32'd1, 16'h0001, 5'd2, 5'd2, 32'd0, 5'd0, 0, 0, 0, 0, 0));
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d data", c), res_data, 32'd123);
            chk($sformatf("bp%0d dest_wb", c), {26'd0, res_dest, res_wb}, {26'd0, 5'd9, 1'b1});
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d alu_x", c), alu_x, 32'd100);
            chk($sformatf("bp%0d mem_wr", c), 32'(mem_wr), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release_valid", 32'(out_valid), 32'd0);
        chk("bp release_ready", 32'(in_ready), 32'd1);

        // Reset asserted while the instruction is in EXEC.
        @(negedge clk);
        drive(mk(6'h23, 6'h00, 32'h2000, 32'd0, 16'h0010, 5'd5, 5'd6, 32'd0, 5'd0, 0, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_exec pre_valid", 32'(out_valid), 32'd0);
        chk("rst_exec pre_sel", 32'(alu_sel), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst_exec");
        @(posedge clk); #1;
        chk("rst_exec hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(vq[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sits in front of the 32-bit integer ALU in the execute stage. It decodes a MIPS-style instruction (opcode/funct/immediate) and registers the ALU operands and 3-bit select. It captures the ALU result and zero flag one cycle later and presents a registered result under a valid/ready handshake. It also handles the branch decision for beq, address generation for lw/sw, and reports illegal opcodes and divide-by-zero.

## Interface
Parameters:
- none. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  sequencer can accept an instruction (high only in IDLE).
- opcode  in  6  instruction opcode.
- funct  in  6  R-type function field.
- rs_val  in  32  source operand 1.
- rt_val  in  32  source operand 2.
- imm  in  16  immediate field.
- rt_idx  in  5  rt register index.
- rd_idx  in  5  rd register index.
- alu_x  out  32  registered ALU operand X.
- alu_y  out  32  registered ALU operand Y.
- alu_sel  out  3  registered ALU select.
- alu_r  in  32  ALU result (combinational from alu_x/alu_y/alu_sel).
- alu_z  in  1  ALU zero flag.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- res_data  out  32  captured ALU result, or 0 on error.
- res_dest  out  5  writeback index: rd for R-type, rt for I-type and lw.
- res_wb  out  1  register writeback required.
- mem_rd / mem_wr  out  1 each  lw / sw; res_data is the effective address.
- br_taken  out  1  beq taken (alu_z = 1).
- err  out  1  illegal opcode/funct, or DIV with rt_val = 0.

## Operation
ALU select codes:
- ADD=0, SUB=1, AND=2, OR=3, SLT=4, MUL=5, DIV=6, NOP=7.
- The NOP code passes X unchanged.

Decode (funct is used only when opcode = 000000):
- R-type: funct 100000 add → ADD; 100100 → AND; 100101 → OR; 101010 → SLT; 011000 → MUL; 011010 → DIV.
- For all R-type ops: Y = rt_val, dest = rd_idx, wb = 1.
- I-type arithmetic/compare, Y = sign-extended imm: addi 001000 → ADD; slti 001010 → SLT.
- I-type logical, Y = zero-extended imm: andi 001100 → AND; ori 001101 → OR.
- For all I-type ops: dest = rt_idx, wb = 1.
- lw 100011: ADD with Y = SE(imm); mem_rd = 1, wb = 1, dest = rt_idx.
- sw 101011: ADD with Y = SE(imm); mem_wr = 1, wb = 0.
- beq 000100: SUB with Y = rt_val; wb = 0; br_taken = alu_z.
- Any other opcode/funct: sel = NOP, err = 1, wb/mem_rd/mem_wr/br_taken = 0, res_data = 0.
- DIV with rt_val = 0: err = 1, wb = 0, res_data = 0. The ALU output is ignored.
- X = rs_val for all ops.

Arithmetic rules:
- All arithmetic is 32-bit modulo; MUL keeps the low 32 bits.
- SLT/SLTI compare unsigned, matching ALU behaviour.

State machine (states IDLE, EXEC, DONE):
- IDLE: in_ready = 1. When in_valid is high, register alu_x/alu_y/alu_sel and the decoded flags, then go to EXEC.
- EXEC: capture alu_r into res_data and alu_z into br_taken (beq only), then go to DONE.
- DONE: out_valid = 1 and all res_* fields are held stable. When out_ready is high, go to IDLE.

## Timing
- Reset values: state IDLE; in_ready = 1; out_valid = 0; alu_x = 0; alu_y = 0; alu_sel = NOP (7); res_data = 0; res_dest = 0; res_wb, mem_rd, mem_wr, br_taken, err = 0.
- Accept occurs at edge N (in_valid & in_ready).
- EXEC occupies cycle N+1; out_valid is high from cycle N+2. Latency is 2 cycles.
- Minimum issue interval is 3 cycles. in_ready stays 0 in EXEC and DONE, and inputs are ignored there.
- out_valid and all res_* fields stay constant while out_ready = 0, for any number of cycles.
- out_ready high in the first DONE cycle: out_valid drops at the next edge, and in_ready is 1 in that same cycle.
- rst in any state, including EXEC or DONE with a pending result, has priority. The result is discarded and all outputs take their reset values at the next edge.
- alu_x/alu_y/alu_sel change only on accept, so ALU inputs are stable through EXEC and DONE.

## Structure
- Package alu_ctrl_pkg holds:
  - SEL code constants;
  - opcode and funct constants;
  - the state enum (IDLE/EXEC/DONE);
  - a decoded-instruction struct: sel, imm_mode (SE/ZE/REG), dest_sel, wb, mem_rd, mem_wr, is_beq, is_div, illegal.
- Sub-module alu_decode: purely combinational, maps opcode/funct to the decoded struct. The FSM and registers stay in alu_sequencer.
- The ALU is instantiated alongside the sequencer by the parent, not inside it. The bench connects the real ALU.

## Test plan
- add: rs = 7, rt = 5, rd = 3 → after 2 cycles out_valid with res_data = 12, res_dest = 3, res_wb = 1, err = 0.
- addi / andi: rs = 0x10 with imm = 0xFFFF → addi gives 0x0000000F; andi on rs = 0xFFFF00FF gives 0x000000FF (zero-extend).
- beq, equal and unequal: rs = rt = 9 → br_taken = 1, res_wb = 0. Then rs = 9, rt = 4 → br_taken = 0, res_data = 5.
- lw / sw: rs = 0x1000, imm = 0xFFFC → res_data = 0x00000FFC. lw gives mem_rd = 1, res_dest = rt; sw gives mem_wr = 1, res_wb = 0.
- Error cases: div with rt = 0 → err = 1, res_data = 0, res_wb = 0. opcode 111111 → err = 1, alu_sel = 7.
- Backpressure and reset: hold out_ready = 0 for 5 cycles → outputs stable and in_valid ignored. Assert rst during EXEC → next cycle out_valid = 0, in_ready = 1, all outputs at reset values.
